// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU: instruction-memory controller states,
// the default NOP encoding and the opcode field layout used by the decoder.
package mini_cpu_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_IDLE = 2'd1,
        ST_LOAD = 2'd2
    } imem_state_e;

    localparam logic [7:0] NOP_INSN = 8'h00;

    // Opcode occupies the upper nibble of an 8-bit instruction
    localparam int         OPC_MSB = 7;
    localparam int         OPC_LSB = 4;
    localparam logic [3:0] OPC_NOP = 4'h0;
    localparam logic [3:0] OPC_LDI = 4'h1;
    localparam logic [3:0] OPC_ADD = 4'h2;
    localparam logic [3:0] OPC_SUB = 4'h3;
    localparam logic [3:0] OPC_JMP = 4'hE;
    localparam logic [3:0] OPC_HLT = 4'hF;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W instruction array: one synchronous write port and one
// registered read port with read enable. The read register clears on reset.
module imem_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Loadable instruction memory: registered fetch port, streaming load port and
// a fill engine that writes NOP everywhere after reset and past a short load.
module imem_loader
    import mini_cpu_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 4,
    parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_INSN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              load_done,
    output logic [ADDR_W:0]   load_count,
    output logic              busy
);

    localparam int              DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR  = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);

    imem_state_e       state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              from_load_q, from_load_d;
    logic [ADDR_W:0]   load_count_q, load_count_d;
    logic              load_done_q, load_done_d;
    logic              fetch_valid_q, fetch_valid_d;

    logic              ram_we, ram_re;
    logic [DATA_W-1:0] ram_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_FILL;
            ptr_q         <= '0;
            from_load_q   <= 1'b0;
            load_count_q  <= '0;
            load_done_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            from_load_q   <= from_load_d;
            load_count_q  <= load_count_d;
            load_done_q   <= load_done_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        from_load_d   = from_load_q;
        load_count_d  = load_count_q;
        load_done_d   = 1'b0;
        fetch_valid_d = 1'b0;
        ram_we        = 1'b0;
        ram_re        = 1'b0;
        ram_wdata     = NOP;

        unique case (state_q)
            ST_FILL: begin
                ram_we = 1'b1;
                ptr_d  = ptr_q + ADDR_W'(1);
                if (ptr_q == LAST_PTR) begin
                    state_d     = ST_IDLE;
                    load_done_d = from_load_q;
                    from_load_d = 1'b0;
                end
            end
            ST_IDLE: begin
                // A same-cycle load_start still reads the old contents here
                if (fetch_req) begin
                    ram_re        = 1'b1;
                    fetch_valid_d = 1'b1;
                end
                if (load_start) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    ram_we    = 1'b1;
                    ram_wdata = load_data;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    if (ptr_q == LAST_PTR) begin
                        load_count_d = FULL_CNT;
                        load_done_d  = 1'b1;
                        state_d      = ST_IDLE;
                    end else if (load_last) begin
                        load_count_d = {1'b0, ptr_q} + (ADDR_W+1)'(1);
                        from_load_d  = 1'b1;
                        state_d      = ST_FILL;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
                ptr_d   = '0;
            end
        endcase
    end

    imem_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we & ~rst),
        .waddr_i (ptr_q),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (fetch_addr),
        .rdata_o (fetch_data)
    );

    assign fetch_valid = fetch_valid_q;
    assign load_done   = load_done_q;
    assign load_count  = load_count_q;
    assign load_ready  = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader (DATA_W=8, ADDR_W=4): reset fill, short,
// full, gapped and aborted loads, plus a fetch colliding with load_start.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_req;
    logic [3:0] fetch_addr;
    logic       fetch_valid;
    logic [7:0] fetch_data;
    logic       load_start;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;
    logic       load_done;
    logic [4:0] load_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    imem_loader #(.DATA_W(8), .ADDR_W(4), .NOP(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .load_start  (load_start),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_last   (load_last),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .load_count  (load_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         phase;
        logic [3:0] addr;
        logic [7:0] exp;
    } fvec_t;

    fvec_t ftab [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_fetch(input logic [3:0] addr, input logic [7:0] exp);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        tick();
        fetch_req  = 1'b0;
        check($sformatf("fetch_valid[%0d]", addr), int'(fetch_valid), 1);
        check($sformatf("fetch_data[%0d]", addr), int'(fetch_data), int'(exp));
    endtask

    task automatic run_phase(input int ph);
        for (int i = 0; i < 12; i++) begin
            if (ftab[i].phase == ph) do_fetch(ftab[i].addr, ftab[i].exp);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_ready_after_start", int'(load_ready), 1);
    endtask

    task automatic send_word(input logic [7:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Counts edges until load_done, bounded so a stuck DUT still ends the run
    task automatic wait_done(input string name, input int exp_cycles);
        int n = 0;
        while (load_done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check({name, "_fill_cycles"}, n, exp_cycles);
        tick();
        check({name, "_done_pulse_width"}, int'(load_done), 0);
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        int seen_done = 0;
        while (busy === 1'b1 && n < 40) begin
            tick();
            n++;
            if (load_done === 1'b1) seen_done++;
        end
        check({name, "_busy_cycles"}, n, 16);
        check({name, "_no_load_done"}, seen_done, 0);
    endtask

    initial begin
        ftab[0]  = '{1, 4'd5,  8'h00};
        ftab[1]  = '{2, 4'd2,  8'h64};
        ftab[2]  = '{2, 4'd4,  8'h00};
        ftab[3]  = '{2, 4'd0,  8'h05};
        ftab[4]  = '{3, 4'd15, 8'h1F};
        ftab[5]  = '{3, 4'd4,  8'h14};
        ftab[6]  = '{4, 4'd0,  8'hA1};
        ftab[7]  = '{4, 4'd2,  8'hA3};
        ftab[8]  = '{4, 4'd3,  8'h00};
        ftab[9]  = '{4, 4'd1,  8'hA2};
        ftab[10] = '{6, 4'd0,  8'h00};
        ftab[11] = '{6, 4'd1,  8'h00};

        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
        load_start = 1'b0; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        repeat (3) tick();
        check("rst_busy", int'(busy), 1);
        check("rst_fetch_valid", int'(fetch_valid), 0);
        check("rst_fetch_data", int'(fetch_data), 0);
        check("rst_load_done", int'(load_done), 0);
        check("rst_load_count", int'(load_count), 0);
        check("rst_load_ready", int'(load_ready), 0);
        rst = 1'b0;
        count_busy("reset");
        run_phase(1);
        tick();
        check("fetch_valid_drops", int'(fetch_valid), 0);
        check("fetch_data_holds", int'(fetch_data), 0);

        // Short load: 4 words, then 12 FILL cycles
        start_load();
        send_word(8'h05, 1'b0);
        send_word(8'h13, 1'b0);
        send_word(8'h64, 1'b0);
        send_word(8'hE4, 1'b1);
        check("short_busy_in_fill", int'(busy), 1);
        wait_done("short", 12);
        check("short_load_count", int'(load_count), 4);
        run_phase(2);

        // Full load: no FILL, done on the cycle after word 15
        start_load();
        for (int i = 0; i < 16; i++) send_word(8'h10 + 8'(i), 1'b0);
        check("full_busy", int'(busy), 0);
        wait_done("full", 0);
        check("full_load_count", int'(load_count), 16);
        run_phase(3);

        // Gapped stream with a fetch attempted during a gap
        start_load();
        send_word(8'hA1, 1'b0);
        fetch_req = 1'b1; fetch_addr = 4'd15;
        tick();
        fetch_req = 1'b0;
        check("load_fetch_ignored", int'(fetch_valid), 0);
        send_word(8'hA2, 1'b0);
        tick();
        check("gap_still_loading", int'(load_ready), 1);
        send_word(8'hA3, 1'b1);
        wait_done("gapped", 13);
        check("gapped_load_count", int'(load_count), 3);
        run_phase(4);

        // Put 0x55 at address 7 via an 8-word load
        start_load();
        for (int i = 0; i < 8; i++)
            send_word((i == 7) ? 8'h55 : 8'h40 + 8'(i), i == 7);
        wait_done("eight", 8);
        check("eight_load_count", int'(load_count), 8);

        // Fetch and load_start in the same cycle
        fetch_req = 1'b1; fetch_addr = 4'd7; load_start = 1'b1;
        tick();
        fetch_req = 1'b0; load_start = 1'b0;
        check("simul_fetch_data", int'(fetch_data), 8'h55);
        check("simul_fetch_valid", int'(fetch_valid), 1);
        check("simul_load_ready", int'(load_ready), 1);

        // Reset after two words of that load
        send_word(8'hEE, 1'b0);
        send_word(8'hEF, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_load_count", int'(load_count), 0);
        check("abort_load_ready", int'(load_ready), 0);
        count_busy("abort");
        check("abort_count_after_fill", int'(load_count), 0);
        run_phase(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Parametrised, loadable instruction memory for the mini CPU. It is the next generation of the fixed ROM and sits between the program counter and the decoder.

- The fetch port gives a registered read with a valid flag.
- A streaming load port lets the bench (or a boot block) write a program at run time.
- A hardware fill engine writes NOP to every entry after reset, and to the unused tail after a short load.

## Interface
Parameters:
- DATA_W, 8, instruction width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries
- NOP, 0, fill word (DATA_W bits)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  read request, sampled only in IDLE
- fetch_addr  in  ADDR_W  read address (from PC)
- fetch_valid  out  1  fetch_data holds the result of a request accepted on the previous edge
- fetch_data  out  DATA_W  registered instruction; holds its value between requests
- load_start  in  1  begin a new program load, sampled only in IDLE
- load_valid  in  1  load_data is valid this cycle
- load_data  in  DATA_W  next instruction word
- load_last  in  1  marks the final word; qualified by load_valid
- load_ready  out  1  high exactly when state is LOAD
- load_done  out  1  one-cycle pulse on the first IDLE cycle after a load completes
- load_count  out  ADDR_W+1  number of words written by the last completed load
- busy  out  1  high when state is not IDLE; the CPU must stall

## Operation
- States: FILL, IDLE, LOAD. There is an internal write pointer ptr (ADDR_W bits) and a from_load flag.
- Reset values:
  - state = FILL, ptr = 0, from_load = 0
  - fetch_valid = 0, fetch_data = 0, load_done = 0, load_count = 0
  - Memory contents are don't-care until FILL rewrites them.
- FILL:
  - Each edge writes NOP at ptr and increments ptr.
  - When ptr == DEPTH-1 is written: go to IDLE, and set load_done for the next cycle if from_load = 1.
  - from_load is then cleared.
- IDLE:
  - If fetch_req: on the next edge, fetch_data = mem[fetch_addr] and fetch_valid = 1.
  - Otherwise fetch_valid = 0 and fetch_data holds.
  - If load_start: go to LOAD with ptr = 0.
  - A simultaneous fetch_req and load_start is legal. The fetch is serviced with the old contents, then the load begins.
- LOAD:
  - Each edge with load_valid & load_ready writes load_data at ptr and increments ptr.
  - If load_valid is low, nothing is written and the state holds, with no timeout.
  - Word written with load_last at ptr = p < DEPTH-1: load_count = p+1, ptr = p+1, from_load = 1, go to FILL.
  - Word written at ptr = DEPTH-1, with or without load_last: load_count = DEPTH, go directly to IDLE, load_done pulses next cycle.
- In FILL and LOAD:
  - fetch_req and load_start are ignored.
  - fetch_valid = 0; fetch_data holds.
- Reset asserted mid-load or mid-fill:
  - Aborts the operation and restarts FILL from 0.
  - load_count returns to 0; no load_done is produced.
- load_count updates only on load completion.

## Timing
- Fetch latency: 1 cycle (request on edge k, data and valid after edge k).
- After rst deasserts, busy stays high for DEPTH cycles. The first IDLE cycle follows the DEPTH-th edge.
- load_start at edge k: load_ready = 1 from cycle k+1. The first word can be accepted on edge k+1.
- Short load ending at word p: FILL lasts DEPTH-(p+1) cycles, then IDLE with load_done high for 1 cycle.
- Full load: IDLE with load_done on the cycle after the final write.
- busy, load_ready and load_done are registered-state decodes, with no combinational path from inputs.

## Structure
- Shared package mini_cpu_pkg holds:
  - the state encoding localparams (FILL/IDLE/LOAD)
  - the default NOP encoding
  - the opcode field constants used by the decoder
- One sub-module, imem_ram:
  - DEPTH x DATA_W array
  - single synchronous write port
  - synchronous read port with read enable
- The controller owns the FSM, ptr, from_load, load_count and output registers.

## Test plan
All scenarios use DATA_W=8, ADDR_W=4 (DEPTH 16).
- Reset: hold rst 3 cycles, then release → busy = 1 for exactly 16 cycles, then 0. fetch_req at addr 5 → next cycle fetch_valid = 1, fetch_data = 0x00.
- Short load: load_start, then words 0x05, 0x13, 0x64, 0xE4 with load_last on the 4th.
  - Required: 12 FILL cycles, then load_done pulse with load_count = 4.
  - Fetch addr 2 → 0x64; fetch addr 4 → 0x00.
- Full load: 16 words 0x10..0x1F with no load_last.
  - Required: no FILL; IDLE with load_done on the cycle after word 15; load_count = 16.
  - Fetch addr 15 → 0x1F.
- Gapped stream: load_valid toggles 1,0,1,0,1 with load_last on the 3rd word (0xA1, 0xA2, 0xA3).
  - Required: exactly 3 writes, at addresses 0..2; load_count = 3.
  - During LOAD, fetch_req = 1 gives fetch_valid = 0.
- Simultaneous: in IDLE with mem[7] = 0x55, assert fetch_req (addr 7) and load_start together.
  - Required: next cycle fetch_data = 0x55, fetch_valid = 1, load_ready = 1.
- Reset mid-load: assert rst after 2 words.
  - Required: busy for 16 cycles; load_count = 0; no load_done.
  - Fetch of addr 0 and addr 1 → 0x00.
